step_pad_capture: RTL and testbench
===================================

# step_pad_capture

Input front end for the dance pad, sitting directly upstream of the top-level game module `main`. It synchronizes and debounces the raw arrow-pad switches and detects press edges. Each press is stamped with the current game time and queued into a small first-word-fall-through event FIFO. `main` pops events to judge hits against the note chart.

## Interface
- `LANES`, 4: number of pad arrows (left, down, up, right = lanes 0..3).
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `TS_W`, 16: timestamp width.
- `FIFO_DEPTH`, 8: event FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `pad_in`  in  LANES: raw asynchronous pad switches, 1 = stepped.
- `time_tick`  in  1: one-cycle strobe that advances the game timestamp.
- `ev_ready`  in  1: consumer accepts the head event.
- `pad_level`  out  LANES: debounced pad state.
- `pad_press`  out  LANES: one-cycle pulse on each debounced rising edge.
- `ev_valid`  out  1: FIFO non-empty.
- `ev_lane`  out  clog2(LANES): lane of the head event.
- `ev_time`  out  TS_W: timestamp of the head event.
- `overflow`  out  1: sticky flag, a press was dropped.

## Operation
- Synchronizer: two flops per lane (reset 0). The synchronized value is `s`.
- Debounce, per lane: a counter increments each cycle that `s != pad_level`. It clears to 0 in any cycle where `s == pad_level`. When `s != pad_level` and the counter equals `DEBOUNCE_CYCLES-1`, then `pad_level <= s` and the counter clears.
- `pad_press[i]` is registered. It is high exactly in the first cycle that `pad_level[i]` reads 1. Falling edges produce no event.
- Timestamp counter (TS_W bits, reset 0):
  - Increments on `time_tick`.
  - Wraps from 2^TS_W-1 to 0.
  - The value captured for a press is the counter value in the cycle `pad_press` is high.
- Pending registers: one per lane, holding a valid bit and a timestamp.
  - A press sets the lane's pending bit and stores the timestamp.
  - If the lane is already pending and not being drained in that cycle, the new press is dropped, the old timestamp is kept, and `overflow` is set.
  - If the lane is being drained in that same cycle, the new press is accepted: the bit stays set and the timestamp is replaced.
- Arbiter: each cycle, if the FIFO is not full (registered occupancy), it writes the lowest-indexed pending lane into the FIFO and clears that lane's pending bit. At most one write per cycle.
- Full FIFO: no write occurs, even if a pop happens in the same cycle. Pending bits wait and are not dropped.
- FIFO: first-word fall-through.
  - `ev_valid` = not empty; `ev_lane` and `ev_time` show the head entry.
  - Pop occurs on `ev_valid && ev_ready`. `ev_ready` while empty is ignored.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `overflow` is cleared only by `reset`.

## Timing
- Reset values: `pad_level`=0, `pad_press`=0, `ev_valid`=0, `ev_lane`=0, `ev_time`=0, `overflow`=0. Sync flops, counters, timestamp, pending bits and FIFO pointers are all 0.
- Raw-to-level latency: if `pad_in` changes before edge k and stays stable, `pad_level` changes at edge k+1+DEBOUNCE_CYCLES. This is 2 edges of synchronization plus DEBOUNCE_CYCLES edges of counting, minus the overlap of the first count.
- Press-to-event latency: with `pad_press` high in cycle P and the lane winning arbitration immediately, the pending bit is set in cycle P+1, the FIFO write completes at the end of P+1, and `ev_valid` is high in P+2.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no level change and no event.
- Reset asserted mid-operation clears all state immediately; queued and pending events are lost. A pad held through reset release produces a press once DEBOUNCE_CYCLES have elapsed after synchronization.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- **Single press:** reset, tick timestamp to 5, raise `pad_in[2]` and hold. Required: `pad_level[2]` rises 5 edges later, `pad_press[2]` pulses for 1 cycle, and 2 cycles after that `ev_valid`=1 with `ev_lane`=2, `ev_time`=5. Pulse `ev_ready` → `ev_valid`=0.
- **Bounce rejection:** toggle `pad_in[0]` high for 3 cycles, low for 2, repeated 5 times. Required: `pad_level` and `pad_press` stay 0 and no event is produced.
- **Simultaneous press:** all 4 lanes pressed in the same cycle at timestamp 9, `ev_ready`=1. Required: events pop in lane order 0, 1, 2, 3 on consecutive cycles, all with `ev_time`=9.
- **Full FIFO and overflow:** hold `ev_ready`=0 and press lanes 0–3 (4 events, FIFO full). Then release and re-press lane 1 twice. Required: the first re-press is held pending; the second sets `overflow`=1. Drain the FIFO → 5 events total, and `overflow` stays 1.
- **Timestamp wrap:** drive `time_tick` to reach 65535 then 1 more tick, then press lane 3. Required: `ev_time`=0.
- **Reset mid-operation:** with 2 events queued and `pad_in[1]` held, assert `reset` for 2 cycles. Required: all outputs are 0 immediately. After release, exactly one lane-1 event appears 5 edges plus 3 cycles later.

Source files
------------

// File: rtl/step_pad_capture.sv
// Dance-pad front end: synchronize, debounce and edge-detect the arrow
// switches, timestamp each press and queue it in a small FWFT FIFO.
module step_pad_capture #(
  parameter int LANES           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TS_W            = 16,
  parameter int FIFO_DEPTH      = 8,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] pad_in,
  input  logic             time_tick,
  input  logic             ev_ready,
  output logic [LANES-1:0] pad_level,
  output logic [LANES-1:0] pad_press,
  output logic             ev_valid,
  output logic [LW-1:0]    ev_lane,
  output logic [TS_W-1:0]  ev_time,
  output logic             overflow
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [LANES-1:0] sync1;
  logic [LANES-1:0] sync2;
  logic [CW-1:0]    cnt [LANES];
  logic [LANES-1:0] commit;
  logic [TS_W-1:0]  ts;

  logic [LANES-1:0] pend_v;
  logic [TS_W-1:0]  pend_t [LANES];

  logic [PW:0]      count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    mem_lane [FIFO_DEPTH];
  logic [TS_W-1:0]  mem_time [FIFO_DEPTH];

  logic             full;
  logic             push;
  logic             pop;
  logic [LW-1:0]    grant;
  logic [LANES-1:0] drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < LANES; i++)
      commit[i] = (sync2[i] != pad_level[i]) && (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_level <= '0;
      pad_press <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      pad_press <= commit & sync2;
      for (int i = 0; i < LANES; i++) begin
        if (sync2[i] == pad_level[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          cnt[i]       <= '0;
          pad_level[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else if (time_tick) ts <= ts + 1'b1;
  end

  // Lowest-indexed pending lane wins; full is judged on registered occupancy.
  always_comb begin
    grant = '0;
    push  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_v[i]) begin
        grant = LW'(i);
        push  = 1'b1;
      end
    end
    push  = push & ~full;
    drain = '0;
    if (push) drain[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < LANES; i++) pend_t[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (pad_press[i]) begin
          if (pend_v[i] && !drain[i]) begin
            overflow <= 1'b1;
          end else begin
            pend_v[i] <= 1'b1;
            pend_t[i] <= ts;
          end
        end else if (drain[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  assign ev_valid = (count != '0);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid & ev_ready;
  assign ev_lane  = ev_valid ? mem_lane[rd_ptr] : '0;
  assign ev_time  = ev_valid ? mem_time[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_lane[wr_ptr] <= grant;
      mem_time[wr_ptr] <= pend_t[grant];
    end
  end

endmodule

// File: tb/tb_step_pad_capture.sv
// Bench for step_pad_capture: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference.
module tb_step_pad_capture;

  localparam int L  = 4;
  localparam int DB = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pad_in = '0;
  logic        time_tick = 1'b0;
  logic        ev_ready = 1'b0;
  logic [3:0]  pad_level;
  logic [3:0]  pad_press;
  logic        ev_valid;
  logic [1:0]  ev_lane;
  logic [15:0] ev_time;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  step_pad_capture #(
    .LANES(L),
    .DEBOUNCE_CYCLES(DB),
    .TS_W(16),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pad_in(pad_in),
    .time_tick(time_tick),
    .ev_ready(ev_ready),
    .pad_level(pad_level),
    .pad_press(pad_press),
    .ev_valid(ev_valid),
    .ev_lane(ev_lane),
    .ev_time(ev_time),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [15:0] t;
  } ev_t;

  logic [3:0]  m_p1;
  logic [3:0]  m_s;
  logic [3:0]  m_lvl;
  logic [3:0]  m_prs;
  int          m_run [L];
  logic [15:0] m_ts;
  bit          m_pv [L];
  logic [15:0] m_pt [L];
  ev_t         m_q [$];
  bit          m_ovf;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_s = '0; m_lvl = '0; m_prs = '0;
    m_ts = '0; m_ovf = 1'b0;
    for (int i = 0; i < L; i++) begin
      m_run[i] = 0; m_pv[i] = 1'b0; m_pt[i] = '0;
    end
    m_q.delete();
  endtask

  // One clock edge: all decisions use the state from before the edge.
  task automatic model_edge();
    bit   pop;
    int   g;
    ev_t  nw;
    logic [3:0] nprs;
    pop = (m_q.size() > 0) && ev_ready;
    g = -1;
    if (m_q.size() < FD)
      for (int i = 0; i < L; i++)
        if (m_pv[i] && g < 0) g = i;
    if (g >= 0) begin
      nw.lane = g;
      nw.t    = m_pt[g];
    end
    for (int i = 0; i < L; i++) begin
      if (m_prs[i]) begin
        if (m_pv[i] && g != i) m_ovf = 1'b1;
        else begin
          m_pv[i] = 1'b1;
          m_pt[i] = m_ts;
        end
      end else if (g == i) begin
        m_pv[i] = 1'b0;
      end
    end
    nprs = '0;
    for (int i = 0; i < L; i++) begin
      if (m_s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s[i];
          m_run[i] = 0;
          nprs[i]  = m_s[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_prs = nprs;
    m_s   = m_p1;
    m_p1  = pad_in;
    if (time_tick) m_ts = m_ts + 16'd1;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(nw);
  endtask

  task automatic check_model();
    bit          v;
    logic [1:0]  el;
    logic [15:0] et;
    int          ln;
    v  = m_q.size() > 0;
    ln = v ? m_q[0].lane : 0;
    el = ln[1:0];
    et = v ? m_q[0].t : 16'd0;
    chk("model",
        {pad_level, pad_press, ev_valid, ev_lane, ev_time, overflow},
        {m_lvl, m_prs, v, el, et, m_ovf});
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    pad_in = '0; time_tick = 1'b0; ev_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  pad;
    logic        tick;
    logic        rdy;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic        vld;
    logic [1:0]  lane;
    logic [15:0] t;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int   got_lane [$];
    int   got_time [$];
    int   got_cyc  [$];
    logic bad;
    int   n;
    int   prob;
    bit   seen;

    model_reset();
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("reset_state",
        {pad_level, pad_press, ev_valid, ev_lane, ev_time, overflow}, '0);

    // single press on lane 2 at timestamp 5
    repeat (5) tbl.push_back('{4'h0, 1, 0, 4'h0, 4'h0, 0, 2'd0, 16'd0});
    repeat (5) tbl.push_back('{4'h4, 0, 0, 4'h0, 4'h0, 0, 2'd0, 16'd0});
    tbl.push_back('{4'h4, 0, 0, 4'h4, 4'h4, 0, 2'd0, 16'd0});
    tbl.push_back('{4'h4, 0, 0, 4'h4, 4'h0, 0, 2'd0, 16'd0});
    tbl.push_back('{4'h4, 0, 0, 4'h4, 4'h0, 1, 2'd2, 16'd5});
    tbl.push_back('{4'h4, 0, 1, 4'h4, 4'h0, 0, 2'd0, 16'd0});
    tbl.push_back('{4'h4, 0, 0, 4'h4, 4'h0, 0, 2'd0, 16'd0});
    for (int r = 0; r < tbl.size(); r++) begin
      pad_in    = tbl[r].pad;
      time_tick = tbl[r].tick;
      ev_ready  = tbl[r].rdy;
      step();
      chk($sformatf("vec%0d", r),
          {pad_level, pad_press, ev_valid, ev_lane, ev_time},
          {tbl[r].lvl, tbl[r].prs, tbl[r].vld, tbl[r].lane, tbl[r].t});
    end

    // bounce: 3 high, 2 low, five times
    do_reset();
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pad_in = 4'h1;
      repeat (3) begin
        step();
        bad = bad | (|pad_level) | (|pad_press) | ev_valid;
      end
      pad_in = 4'h0;
      repeat (2) begin
        step();
        bad = bad | (|pad_level) | (|pad_press) | ev_valid;
      end
    end
    repeat (10) begin
      step();
      bad = bad | (|pad_level) | (|pad_press) | ev_valid;
    end
    chk("bounce", bad, 1'b0);

    // simultaneous press at timestamp 9
    do_reset();
    time_tick = 1'b1;
    repeat (9) step();
    time_tick = 1'b0;
    ev_ready  = 1'b1;
    pad_in    = 4'hF;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ev_valid) begin
        got_lane.push_back(int'(ev_lane));
        got_time.push_back(int'(ev_time));
        got_cyc.push_back(c);
      end
    end
    chk("simul_count", got_lane.size(), 4);
    for (int j = 0; j < got_lane.size() && j < 4; j++) begin
      chk($sformatf("simul_lane%0d", j), got_lane[j], j);
      chk($sformatf("simul_time%0d", j), got_time[j], 9);
      if (j > 0)
        chk($sformatf("simul_cyc%0d", j), got_cyc[j] - got_cyc[j-1], 1);
    end

    // full FIFO, one held press, then an overflowing press
    do_reset();
    pad_in = 4'hF;
    repeat (12) step();
    chk("full_valid", ev_valid, 1'b1);
    pad_in = 4'h0;
    repeat (8) step();
    pad_in = 4'h2;
    repeat (8) step();
    chk("held_no_ovf", overflow, 1'b0);
    pad_in = 4'h0;
    repeat (8) step();
    pad_in = 4'h2;
    repeat (8) step();
    chk("ovf_set", overflow, 1'b1);
    ev_ready = 1'b1;
    got_lane.delete();
    repeat (20) begin
      if (ev_valid) got_lane.push_back(int'(ev_lane));
      step();
    end
    chk("drain_count", got_lane.size(), 5);
    for (int j = 0; j < got_lane.size() && j < 5; j++)
      chk($sformatf("drain_lane%0d", j), got_lane[j], (j < 4) ? j : 1);
    chk("ovf_sticky", overflow, 1'b1);

    // reset mid-operation with lane 1 held
    do_reset();
    pad_in = 4'h5;
    repeat (12) step();
    chk("two_queued", {ev_valid, ev_lane}, {1'b1, 2'd0});
    pad_in = 4'h2;
    repeat (2) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_async",
        {pad_level, pad_press, ev_valid, ev_lane, ev_time, overflow}, '0);
    repeat (2) step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e < 8) chk($sformatf("post_rst_idle%0d", e), ev_valid, 1'b0);
    end
    chk("post_rst_ev", {ev_valid, ev_lane, ev_time}, {1'b1, 2'd1, 16'd0});
    ev_ready = 1'b1;
    n = 0;
    repeat (15) begin
      if (ev_valid) n++;
      step();
    end
    chk("post_rst_once", n, 1);

    // timestamp wrap
    do_reset();
    time_tick = 1'b1;
    repeat (65536) step();
    time_tick = 1'b0;
    pad_in = 4'h8;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      step();
      seen = ev_valid;
    end
    chk("wrap_seen", seen, 1'b1);
    chk("wrap_ev", {ev_lane, ev_time}, {2'd3, 16'd0});

    // randomized traffic against the reference model
    do_reset();
    prob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) prob = $urandom_range(0, 100);
      for (int i = 0; i < L; i++)
        if ($urandom_range(0, 9) == 0) pad_in[i] = ~pad_in[i];
      time_tick = $urandom_range(0, 1) == 1;
      ev_ready  = $urandom_range(0, 99) < prob;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
